// File: rtl/turing_ctrl.sv
// turing_ctrl: sequencing controller and register-file tape for a unary-addition
// Turing datapath. A single head rewrites "A^m ADD A^n" into "A^(m+n)" one cell
// per clock, then sweeps the whole tape to count the A cells.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start_i              begin a run (accepted only in IDLE/DONE)
//   ld_we_i/ld_addr_i/ld_sym_i   tape load port (ignored while busy)
//   rd_addr_i/rd_sym_o   combinational debug read (BLANK beyond DEPTH)
//   busy_o, done_o, err_o        status; done/err are sticky until next start
//   result_o             number of A cells after the run
//   steps_o              cycles spent in SEEK..COUNT, saturating
module turing_ctrl #(
    parameter int unsigned DEPTH = 19,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          ld_we_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [1:0]    ld_sym_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [1:0]    rd_sym_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [31:0]   result_o,
    output logic [15:0]   steps_o
);

    localparam logic [1:0]    SymA     = 2'b00;
    localparam logic [1:0]    SymAdd   = 2'b01;
    localparam logic [1:0]    SymBlank = 2'b10;
    localparam logic [1:0]    SymIll   = 2'b11;
    localparam logic [AW-1:0] LastCell = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle, StSeek, StScan, StFindEnd, StErase, StCount, StError, StDone
    } state_e;

    state_e        state_q;
    logic [1:0]    tape_q [DEPTH];
    logic [AW-1:0] head_q;
    logic          busy_q, done_q, err_q;
    logic [31:0]   result_q;
    logic [15:0]   steps_q;

    logic [1:0] head_sym;
    logic       at_last;
    logic       counting;

    always_comb begin
        head_sym = SymBlank;
        if (32'(head_q) < DEPTH) head_sym = tape_q[head_q];
        rd_sym_o = SymBlank;
        if (32'(rd_addr_i) < DEPTH) rd_sym_o = tape_q[rd_addr_i];
        at_last  = (head_q == LastCell);
        counting = (state_q == StSeek) || (state_q == StScan) || (state_q == StFindEnd) ||
                   (state_q == StErase) || (state_q == StCount);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            head_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            steps_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) tape_q[i] <= SymBlank;
        end else begin
            if (counting && steps_q != 16'hFFFF) steps_q <= steps_q + 16'd1;
            unique case (state_q)
                StIdle, StDone: begin
                    // Load lands on the same edge as start, so the run sees it.
                    if (ld_we_i && 32'(ld_addr_i) < DEPTH) tape_q[ld_addr_i] <= ld_sym_i;
                    if (start_i) begin
                        head_q   <= '0;
                        steps_q  <= '0;
                        result_q <= '0;
                        done_q   <= 1'b0;
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= StSeek;
                    end
                end
                StSeek: begin
                    // Every SEEK outcome moves right, so the last cell is an error.
                    if (head_sym == SymIll || at_last) begin
                        state_q <= StError;
                    end else begin
                        head_q <= head_q + 1'b1;
                        if (head_sym == SymA) begin
                            state_q <= StScan;
                        end else if (head_sym == SymAdd) begin
                            tape_q[head_q] <= SymA;
                            state_q        <= StFindEnd;
                        end
                    end
                end
                StScan: begin
                    if (head_sym == SymIll) begin
                        state_q <= StError;
                    end else if (head_sym == SymBlank) begin
                        head_q  <= '0;
                        state_q <= StCount;
                    end else if (at_last) begin
                        state_q <= StError;
                    end else begin
                        head_q <= head_q + 1'b1;
                        if (head_sym == SymAdd) begin
                            tape_q[head_q] <= SymA;
                            state_q        <= StFindEnd;
                        end
                    end
                end
                StFindEnd: begin
                    if (head_sym == SymIll) begin
                        state_q <= StError;
                    end else if (head_sym == SymBlank) begin
                        head_q  <= head_q - 1'b1;
                        state_q <= StErase;
                    end else if (at_last) begin
                        state_q <= StError;
                    end else begin
                        head_q <= head_q + 1'b1;
                    end
                end
                StErase: begin
                    // The merged run is one A too long; drop its rightmost cell.
                    tape_q[head_q] <= SymBlank;
                    head_q         <= '0;
                    state_q        <= StCount;
                end
                StCount: begin
                    if (head_sym == SymA) result_q <= result_q + 32'd1;
                    if (at_last) begin
                        head_q  <= '0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end else begin
                        head_q <= head_q + 1'b1;
                    end
                end
                StError: begin
                    err_q   <= 1'b1;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign result_o = result_q;
    assign steps_o  = steps_q;

endmodule

// File: tb/tb_turing_ctrl.sv
// Directed bench for turing_ctrl: unary additions, error cases and mid-run reset.
module tb_turing_ctrl;

    localparam int DEPTH = 19;
    localparam int AW    = 5;
    localparam logic [1:0] A = 2'b00, ADD = 2'b01, BL = 2'b10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          ld_we_i = 1'b0;
    logic [AW-1:0] ld_addr_i = '0;
    logic [1:0]    ld_sym_i = BL;
    logic [AW-1:0] rd_addr_i = '0;
    logic [1:0]    rd_sym_o;
    logic          busy_o, done_o, err_o;
    logic [31:0]   result_o;
    logic [15:0]   steps_o;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned edges;

    always #5 clk = ~clk;

    turing_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .ld_we_i  (ld_we_i),
        .ld_addr_i(ld_addr_i),
        .ld_sym_i (ld_sym_i),
        .rd_addr_i(rd_addr_i),
        .rd_sym_o (rd_sym_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .result_o (result_o),
        .steps_o  (steps_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic rd_chk(input string tag, input int addr, input logic [1:0] exp);
        rd_addr_i = AW'(addr);
        @(negedge clk);
        chk($sformatf("%s[%0d]", tag, addr), 32'(rd_sym_o), 32'(exp));
    endtask

    task automatic wr(input int addr, input logic [1:0] sym);
        ld_we_i   = 1'b1;
        ld_addr_i = AW'(addr);
        ld_sym_i  = sym;
        tick();
        ld_we_i = 1'b0;
    endtask

    task automatic clear_tape();
        for (int i = 0; i < DEPTH; i++) wr(i, BL);
    endtask

    // Counts edges after the start edge until done rises (bounded).
    task automatic run(output int unsigned n);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (!done_o && n < 500) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #12;
        chk("reset busy", 32'(busy_o), 0);
        chk("reset done", 32'(done_o), 0);
        chk("reset err", 32'(err_o), 0);
        chk("reset result", result_o, 0);
        chk("reset steps", 32'(steps_o), 0);
        rd_chk("reset tape", 0, BL);
        rst_n = 1'b1;
        tick();

        // 1: A^3 ADD A^4 at cells 6..13
        for (int i = 6; i <= 8; i++) wr(i, A);
        wr(9, ADD);
        for (int i = 10; i <= 13; i++) wr(i, A);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("t1 busy after start", 32'(busy_o), 1);
        chk("t1 done after start", 32'(done_o), 0);
        edges = 0;
        while (!done_o && edges < 500) begin
            tick();
            edges++;
        end
        chk("t1 edges", edges, 35);
        chk("t1 done", 32'(done_o), 1);
        chk("t1 busy", 32'(busy_o), 0);
        chk("t1 result", result_o, 7);
        chk("t1 err", 32'(err_o), 0);
        chk("t1 steps", 32'(steps_o), 35);
        for (int i = 0; i < DEPTH; i++) rd_chk("t1 tape", i, (i >= 6 && i <= 12) ? A : BL);

        // 2: ADD at 0 followed by A A
        clear_tape();
        wr(0, ADD);
        wr(1, A);
        wr(2, A);
        run(edges);
        chk("t2 done", 32'(done_o), 1);
        chk("t2 result", result_o, 2);
        chk("t2 err", 32'(err_o), 0);
        chk("t2 steps", 32'(steps_o), 24);
        chk("t2 edges", edges, 24);
        rd_chk("t2 tape", 0, A);
        rd_chk("t2 tape", 1, A);
        rd_chk("t2 tape", 2, BL);

        // 3: A^3 with no ADD: count only, tape untouched
        clear_tape();
        for (int i = 3; i <= 5; i++) wr(i, A);
        run(edges);
        chk("t3 done", 32'(done_o), 1);
        chk("t3 result", result_o, 3);
        chk("t3 err", 32'(err_o), 0);
        chk("t3 steps", 32'(steps_o), 26);
        for (int i = 0; i < DEPTH; i++) rd_chk("t3 tape", i, (i >= 3 && i <= 5) ? A : BL);

        // 4: A at 17..18 runs off the right edge
        clear_tape();
        wr(17, A);
        wr(18, A);
        run(edges);
        chk("t4 done", 32'(done_o), 1);
        chk("t4 err", 32'(err_o), 1);
        chk("t4 result", result_o, 0);
        chk("t4 steps", 32'(steps_o), 19);
        chk("t4 busy", 32'(busy_o), 0);

        // 5: all BLANK
        clear_tape();
        run(edges);
        chk("t5 done", 32'(done_o), 1);
        chk("t5 err", 32'(err_o), 1);
        chk("t5 steps", 32'(steps_o), 19);
        chk("t5 result", result_o, 0);

        // 6: reset during COUNT of the first tape
        for (int i = 6; i <= 8; i++) wr(i, A);
        wr(9, ADD);
        for (int i = 10; i <= 13; i++) wr(i, A);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (20) tick();
        chk("t6 busy in count", 32'(busy_o), 1);
        chk("t6 steps in count", 32'(steps_o), 20);
        rst_n = 1'b0;
        #1;
        chk("t6 rst busy", 32'(busy_o), 0);
        chk("t6 rst done", 32'(done_o), 0);
        chk("t6 rst result", result_o, 0);
        chk("t6 rst steps", 32'(steps_o), 0);
        for (int i = 0; i < 32; i++) rd_chk("t6 rst tape", i, BL);
        rst_n = 1'b1;
        tick();

        // 7: start and load while busy are ignored (blank tape run)
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (5) tick();
        chk("t7 steps before", 32'(steps_o), 5);
        start_i   = 1'b1;
        ld_we_i   = 1'b1;
        ld_addr_i = AW'(10);
        ld_sym_i  = ADD;
        tick();
        start_i = 1'b0;
        ld_we_i = 1'b0;
        chk("t7 steps after ignored start", 32'(steps_o), 6);
        chk("t7 busy", 32'(busy_o), 1);
        rd_chk("t7 ignored load", 10, BL);
        edges = 0;
        while (!done_o && edges < 500) begin
            tick();
            edges++;
        end
        chk("t7 done", 32'(done_o), 1);
        chk("t7 err", 32'(err_o), 1);
        chk("t7 steps", 32'(steps_o), 19);
        rd_chk("t7 tape", 10, BL);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
